// File: rtl/sync_trigger_frontend_pkg.sv
// Shared types and defaults for the sync trigger front end.
// State encoding, parameter defaults and a saturating counter helper.
package sync_trigger_frontend_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    localparam int unsigned FILTER_LEN_DEF = 8;
    localparam int unsigned FG_TIMEOUT_DEF = 1_000_000;
    localparam int unsigned HOLDOFF_DEF    = 1000;

    function automatic logic [15:0] sat_add16(
        input logic [15:0] v,
        input logic [1:0]  inc
    );
        logic [16:0] sum;
        sum = {1'b0, v} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/sync_trigger_frontend_input_conditioner.sv
// Input conditioner: two-flop synchronizer, glitch filter, rise detect.
// Rises are only reported once the line has been seen low after reset.
module input_conditioner
    import sync_trigger_frontend_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic rise
);

    localparam logic [7:0] LAST = 8'(FILTER_LEN - 1);

    logic       sync1;
    logic       sync2;
    logic       level;
    logic       level_d;
    logic       primed;
    logic [7:0] cnt;
    logic [7:0] qcnt;

    // bring the asynchronous line into the clock domain
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // level follows sync2 only after FILTER_LEN disagreeing cycles
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level <= 1'b0;
            cnt   <= 8'd0;
        end else if (sync2 != level) begin
            if (cnt == LAST) begin
                level <= sync2;
                cnt   <= 8'd0;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end else begin
            cnt <= 8'd0;
        end
    end

    // after reset, require a filtered low before any rise counts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            primed <= 1'b0;
            qcnt   <= 8'd0;
        end else if (!primed) begin
            if (sync2) begin
                qcnt <= 8'd0;
            end else if (qcnt == LAST) begin
                primed <= 1'b1;
                qcnt   <= 8'd0;
            end else begin
                qcnt <= qcnt + 8'd1;
            end
        end
    end

    // edge history for the rise detector
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            level_d <= 1'b0;
        end else begin
            level_d <= level;
        end
    end

    assign rise = level & ~level_d & primed;

endmodule

// File: rtl/sync_trigger_frontend.sv
// Trigger front end: conditions start/fg lines and runs IDLE/ARMED/HOLDOFF.
// Optional event counters are built when TRIGGER_COUNT_EN is defined.
module sync_trigger_frontend
    import sync_trigger_frontend_pkg::*;
#(
    parameter int unsigned FILTER_LEN = FILTER_LEN_DEF,
    parameter int unsigned FG_TIMEOUT = FG_TIMEOUT_DEF,
    parameter int unsigned HOLDOFF    = HOLDOFF_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic start_raw,
    input  logic fg_raw,
    output logic start_signal,
    output logic fg_signal,
    output logic busy,
    output logic timeout_pulse
`ifdef TRIGGER_COUNT_EN
    ,
    output logic [15:0] start_count,
    output logic [15:0] fg_count,
    output logic [15:0] drop_count
`endif
);

    localparam logic [31:0] TO_LAST = 32'(FG_TIMEOUT - 1);
    localparam logic [31:0] HO_LAST =
        (HOLDOFF == 0) ? 32'd0 : 32'(HOLDOFF - 1);

    localparam state_t ST_IDLE  = sync_trigger_frontend_pkg::IDLE;
    localparam state_t ST_ARMED = sync_trigger_frontend_pkg::ARMED;
    localparam state_t ST_HOLD  = sync_trigger_frontend_pkg::HOLDOFF;

    logic        start_ev;
    logic        fg_ev;
    state_t      state;
    logic [31:0] cnt;

    input_conditioner #(.FILTER_LEN(FILTER_LEN)) u_start_cond (
        .clock (clock),
        .reset (reset),
        .raw   (start_raw),
        .rise  (start_ev)
    );

    input_conditioner #(.FILTER_LEN(FILTER_LEN)) u_fg_cond (
        .clock (clock),
        .reset (reset),
        .raw   (fg_raw),
        .rise  (fg_ev)
    );

    // trigger sequencing FSM with registered pulse outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            cnt           <= 32'd0;
            start_signal  <= 1'b0;
            fg_signal     <= 1'b0;
            timeout_pulse <= 1'b0;
            busy          <= 1'b0;
        end else begin
            start_signal  <= 1'b0;
            fg_signal     <= 1'b0;
            timeout_pulse <= 1'b0;
            case (state)
                ST_IDLE: begin
                    busy <= 1'b0;
                    if (start_ev) begin
                        start_signal <= 1'b1;
                        cnt          <= 32'd0;
                        state        <= ST_ARMED;
                        busy         <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    busy <= 1'b1;
                    if (fg_ev) begin
                        fg_signal <= 1'b1;
                        cnt       <= 32'd0;
                        state     <= ST_HOLD;
                    end else if (cnt >= TO_LAST) begin
                        timeout_pulse <= 1'b1;
                        cnt           <= 32'd0;
                        state         <= ST_IDLE;
                        busy          <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_HOLD: begin
                    busy <= 1'b1;
                    if (cnt >= HO_LAST) begin
                        cnt   <= 32'd0;
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + 32'd1;
                    end
                end
                default: begin
                    cnt   <= 32'd0;
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef TRIGGER_COUNT_EN
    logic       acc_start;
    logic       acc_fg;
    logic [1:0] drop_inc;

    // classify this cycle's events as accepted or dropped
    always_comb begin
        acc_start = 1'b0;
        acc_fg    = 1'b0;
        drop_inc  = 2'd0;
        case (state)
            ST_IDLE: begin
                acc_start = start_ev;
                drop_inc  = {1'b0, fg_ev};
            end
            ST_ARMED: begin
                acc_fg   = fg_ev;
                drop_inc = {1'b0, start_ev};
            end
            default: begin
                drop_inc = {1'b0, start_ev} + {1'b0, fg_ev};
            end
        endcase
    end

    // saturating event counters
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_count <= 16'd0;
            fg_count    <= 16'd0;
            drop_count  <= 16'd0;
        end else begin
            start_count <= sat_add16(start_count, {1'b0, acc_start});
            fg_count    <= sat_add16(fg_count, {1'b0, acc_fg});
            drop_count  <= sat_add16(drop_count, drop_inc);
        end
    end
`endif

endmodule

// File: tb/tb_sync_trigger_frontend.sv
// Directed bench for sync_trigger_frontend (FILTER_LEN=8,
// FG_TIMEOUT=100, HOLDOFF=1000); counter checks when TRIGGER_COUNT_EN.
module tb_sync_trigger_frontend;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic start_raw = 1'b0;
    logic fg_raw = 1'b0;
    logic start_signal;
    logic fg_signal;
    logic busy;
    logic timeout_pulse;
`ifdef TRIGGER_COUNT_EN
    logic [15:0] start_count;
    logic [15:0] fg_count;
    logic [15:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    bit tr_b [0:1099];
    int ns, nf, nt, nb, nx;
    int fs, ff, ft;

    always #5 clock = ~clock;

    sync_trigger_frontend #(
        .FILTER_LEN (8),
        .FG_TIMEOUT (100),
        .HOLDOFF    (1000)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start_raw     (start_raw),
        .fg_raw        (fg_raw),
        .start_signal  (start_signal),
        .fg_signal     (fg_signal),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
`ifdef TRIGGER_COUNT_EN
        ,
        .start_count   (start_count),
        .fg_count      (fg_count),
        .drop_count    (drop_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive raw windows from the current negedge (index 0) and record
    // outputs at each following negedge (index i+1).
    task automatic run(input int n,
                       input int s0, input int s1,
                       input int s2, input int s3,
                       input int f0, input int f1,
                       input int f2, input int f3);
        ns = 0; nf = 0; nt = 0; nb = 0; nx = 0;
        fs = -1; ff = -1; ft = -1;
        for (int i = 0; i < n; i++) begin
            start_raw = (i >= s0 && i < s1) || (i >= s2 && i < s3);
            fg_raw    = (i >= f0 && i < f1) || (i >= f2 && i < f3);
            @(negedge clock);
            tr_b[i + 1] = busy;
            if (busy) nb++;
            if (start_signal) begin
                ns++;
                if (fs < 0) fs = i + 1;
            end
            if (fg_signal) begin
                nf++;
                if (ff < 0) ff = i + 1;
            end
            if (timeout_pulse) begin
                nt++;
                if (ft < 0) ft = i + 1;
            end
            if (int'(start_signal) + int'(fg_signal)
                + int'(timeout_pulse) > 1) nx++;
        end
    endtask

    initial begin
        // reset state
        @(negedge clock);
        @(negedge clock);
        chk("rst_start", 32'(start_signal), 0);
        chk("rst_fg", 32'(fg_signal), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_timeout", 32'(timeout_pulse), 0);
        reset = 1'b0;
        run(15, 0, 0, 0, 0, 0, 0, 0, 0);

        // short start pulse is filtered out
        run(25, 0, 5, 0, 0, 0, 0, 0, 0);
        chk("short_start_pulses", 32'(ns), 0);
        chk("short_start_busy", 32'(nb), 0);

        // fg in IDLE is dropped
        run(30, 0, 0, 0, 0, 0, 12, 0, 0);
        chk("idle_fg_pulses", 32'(nf), 0);
`ifdef TRIGGER_COUNT_EN
        chk("idle_fg_drop_count", 32'(drop_count), 1);
`endif

        // start latency and ARMED timeout
        run(130, 0, 20, 0, 0, 0, 0, 0, 0);
        chk("a_start_idx", fs, 11);
        chk("a_start_cnt", ns, 1);
        chk("a_busy_armed", 32'(tr_b[12]), 1);
        chk("a_timeout_idx", ft, 111);
        chk("a_timeout_cnt", nt, 1);
        chk("a_fg_cnt", nf, 0);
        chk("a_busy_before_to", 32'(tr_b[110]), 1);
        chk("a_busy_after_to", 32'(tr_b[111]), 0);

        // start, fg 50 cycles later, holdoff ignores a second start
        run(1080, 0, 20, 200, 220, 50, 70, 0, 0);
        chk("b_start_cnt", ns, 1);
        chk("b_start_idx", fs, 11);
        chk("b_fg_cnt", nf, 1);
        chk("b_fg_idx", ff, 61);
        chk("b_timeout_cnt", nt, 0);
        chk("b_busy_hold_end", 32'(tr_b[1060]), 1);
        chk("b_busy_fall", 32'(tr_b[1061]), 0);
        chk("b_exclusive", nx, 0);

        // simultaneous start+fg in IDLE, later fg accepted
        run(1080, 0, 20, 0, 0, 0, 20, 40, 60);
        chk("c_start_cnt", ns, 1);
        chk("c_start_idx", fs, 11);
        chk("c_fg_cnt", nf, 1);
        chk("c_fg_idx", ff, 51);
        chk("c_timeout_cnt", nt, 0);
        chk("c_busy_hold_end", 32'(tr_b[1050]), 1);
        chk("c_busy_fall", 32'(tr_b[1051]), 0);
        chk("c_exclusive", nx, 0);
`ifdef TRIGGER_COUNT_EN
        chk("cnt_start", 32'(start_count), 3);
        chk("cnt_fg", 32'(fg_count), 2);
        chk("cnt_drop", 32'(drop_count), 3);
`endif

        // reset mid-ARMED with start held high
        run(30, 0, 100000, 0, 0, 0, 0, 0, 0);
        chk("d_start_idx", fs, 11);
        reset = 1'b1;
        #1;
        chk("d_rst_start", 32'(start_signal), 0);
        chk("d_rst_fg", 32'(fg_signal), 0);
        chk("d_rst_busy", 32'(busy), 0);
        chk("d_rst_timeout", 32'(timeout_pulse), 0);
        @(negedge clock);
        reset = 1'b0;
        run(40, 0, 40, 0, 0, 0, 0, 0, 0);
        chk("d_held_no_start", ns, 0);
        chk("d_held_no_busy", nb, 0);
        chk("d_held_no_timeout", nt, 0);
        run(60, 20, 40, 0, 0, 0, 0, 0, 0);
        chk("d_restart_cnt", ns, 1);
        chk("d_restart_idx", fs, 31);
`ifdef TRIGGER_COUNT_EN
        chk("d_cnt_start", 32'(start_count), 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
